mem_arbiter_2x1: RTL and testbench

Two-requester memory arbiter that shares the single 64 MB memory instance between the processor and a second bus master (DMA/loader). It serialises requests with a round-robin policy, drives the memory READ/WRITE/ADDR/DATA strobes for a fixed access window, and returns read data with a one-cycle acknowledge pulse. It sits between the processor/second master and the memory, in the system top-level.

---
 rtl/mem_arbiter_2x1.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter_2x1.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2x1.sv
// Two-requester round-robin arbiter in front of a single memory: latches the
// winner's request, holds registered strobes for MEM_LATENCY cycles, then acks.

// Per-requester response slice: read-data holding register and ack pulse.
module mem_arb_port #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  done,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= done;
            if (done && rd)
                rdata <= mem_data;
        end
    end
endmodule

module mem_arbiter_2x1 #(
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic [DATA_WIDTH-1:0] RDATA0,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_DATA_IN,
    input  logic [DATA_WIDTH-1:0] MEM_DATA_OUT
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t     state, state_n;
    req_t [1:0] req_in;
    req_t       cur, nxt;
    logic [1:0] req;
    logic [3:0] cnt, cnt_n;
    logic       last, gnt_id, gnt_sel, grant, done;

    logic [1:0][DATA_WIDTH-1:0] rdata_arr;
    logic [1:0]                 ack_arr;

    assign req       = {REQ1, REQ0};
    assign req_in[0] = {WE0, ADDR0, WDATA0};
    assign req_in[1] = {WE1, ADDR1, WDATA1};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant   = 1'b0;
        gnt_sel = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (|req) begin
                grant   = 1'b1;
                // On a tie the requester that did not win last time goes next.
                gnt_sel = (&req) ? ~last : req[1];
                cnt_n   = 4'(MEM_LATENCY);
                state_n = ACCESS;
            end
            ACCESS: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_n = DONE;
                    done    = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        nxt = grant ? req_in[gnt_sel] : cur;
    end

    // Strobes are computed from next state so they are true flops aligned with ACCESS.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            last        <= 1'b1;
            cnt         <= '0;
            cur         <= '0;
            gnt_id      <= 1'b0;
            MEM_READ    <= 1'b0;
            MEM_WRITE   <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_DATA_IN <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (grant) begin
                cur    <= req_in[gnt_sel];
                gnt_id <= gnt_sel;
                last   <= gnt_sel;
            end
            MEM_READ    <= (state_n == ACCESS) && !nxt.we;
            MEM_WRITE   <= (state_n == ACCESS) && nxt.we;
            MEM_ADDR    <= (state_n == ACCESS) ? nxt.addr : '0;
            MEM_DATA_IN <= (state_n == ACCESS && nxt.we) ? nxt.wdata : '0;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_port
        mem_arb_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
            .clk      (CLK),
            .rst_n    (RST),
            .done     (done && (gnt_id == 1'(g))),
            .rd       (!cur.we),
            .mem_data (MEM_DATA_OUT),
            .rdata    (rdata_arr[g]),
            .ack      (ack_arr[g])
        );
    end

    assign RDATA0 = rdata_arr[0];
    assign RDATA1 = rdata_arr[1];
    assign ACK0   = ack_arr[0];
    assign ACK1   = ack_arr[1];
endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Bench for mem_arbiter_2x1: directed scenarios on latency-1 and latency-3
// instances plus a random run against a transaction-level arbitration model.
module tb_mem_arbiter_2x1;
    logic        CLK = 1'b0, RST = 1'b0;
    logic        REQ0 = 0, REQ1 = 0, WE0 = 0, WE1 = 0;
    logic [25:0] ADDR0 = '0, ADDR1 = '0;
    logic [31:0] WDATA0 = '0, WDATA1 = '0;
    logic [31:0] RDATA0, RDATA1, MEM_DATA_IN, MEM_DATA_OUT;
    logic        ACK0, ACK1, MEM_READ, MEM_WRITE;
    logic [25:0] MEM_ADDR;
    logic [31:0] l3_rdata0, l3_rdata1, l3_mdin, l3_mdo;
    logic        l3_ack0, l3_ack1, l3_rd, l3_wr;
    logic [25:0] l3_maddr;

    logic [31:0] dmem [0:255];
    int n_chk = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    assign MEM_DATA_OUT = dmem[MEM_ADDR[7:0]];
    assign l3_mdo       = init_val(int'(l3_maddr[7:0]));

    mem_arbiter_2x1 #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .RDATA0(RDATA0), .RDATA1(RDATA1), .ACK0(ACK0), .ACK1(ACK1),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA_IN(MEM_DATA_IN), .MEM_DATA_OUT(MEM_DATA_OUT));

    mem_arbiter_2x1 #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut3 (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .RDATA0(l3_rdata0), .RDATA1(l3_rdata1), .ACK0(l3_ack0), .ACK1(l3_ack1),
        .MEM_READ(l3_rd), .MEM_WRITE(l3_wr), .MEM_ADDR(l3_maddr),
        .MEM_DATA_IN(l3_mdin), .MEM_DATA_OUT(l3_mdo));

    task automatic mem_init();
        for (int i = 0; i < 256; i++) dmem[i] = init_val(i);
        dmem[8'h10] = 32'hDEAD_BEEF;
    endtask

    // Advance to the next falling edge, service memory writes, check strobe exclusivity.
    task automatic tick();
        @(negedge CLK);
        if (MEM_WRITE) dmem[MEM_ADDR[7:0]] = MEM_DATA_IN;
        n_chk++;
        if ((MEM_READ && MEM_WRITE) || (l3_rd && l3_wr)) begin
            n_fail++;
            $display("FAIL strobe_excl: rd/wr both high (L1 %b%b, L3 %b%b), required never", MEM_READ, MEM_WRITE, l3_rd, l3_wr);
        end
    endtask

    task automatic idle_inputs();
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 0; tick(); tick(); RST = 1;
    endtask

    task automatic test_reset();
        logic [255:0] obs;
        idle_inputs();
        RST = 0; tick();
        obs = {MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DATA_IN, ACK0, ACK1, RDATA0, RDATA1,
               l3_rd, l3_wr, l3_maddr, l3_mdin, l3_ack0, l3_ack1, l3_rdata0, l3_rdata1};
        n_chk++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", obs); end
        tick(); RST = 1;
    endtask

    task automatic test_single_read();
        REQ0 = 1; WE0 = 0; ADDR0 = 26'h10;
        tick();
        n_chk++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDR, ACK0, ACK1} !== {1'b1, 1'b0, 26'h10, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL single_read_strobe: rd=%b wr=%b addr=%h ack=%b%b, required 1 0 10 00", MEM_READ, MEM_WRITE, MEM_ADDR, ACK0, ACK1);
        end
        tick();
        n_chk++;
        if ({MEM_READ, MEM_ADDR, ACK0, ACK1, RDATA0} !== {1'b0, 26'h0, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL single_read_ack: rd=%b addr=%h ack=%b%b rdata0=%h, required 0 0 10 deadbeef", MEM_READ, MEM_ADDR, ACK0, ACK1, RDATA0);
        end
        REQ0 = 0;
        tick();
        n_chk++;
        if ({ACK0, ACK1, RDATA0} !== {2'b00, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL single_read_after: ack=%b%b rdata0=%h, required 00 deadbeef", ACK0, ACK1, RDATA0);
        end
    endtask

    task automatic test_write_read();
        REQ1 = 1; WE1 = 1; ADDR1 = 26'h20; WDATA1 = 32'h1234_5678;
        tick();
        n_chk++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DATA_IN} !== {1'b0, 1'b1, 26'h20, 32'h1234_5678}) begin
            n_fail++; $display("FAIL write_strobe: rd=%b wr=%b addr=%h din=%h, required 0 1 20 12345678", MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DATA_IN);
        end
        tick();
        n_chk++;
        if ({ACK0, ACK1, RDATA1, MEM_WRITE} !== {2'b01, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL write_ack: ack=%b%b rdata1=%h wr=%b, required 01 0 0", ACK0, ACK1, RDATA1, MEM_WRITE);
        end
        REQ1 = 0;
        tick();
        REQ1 = 1; WE1 = 0;
        tick();
        n_chk++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DATA_IN} !== {1'b1, 1'b0, 26'h20, 32'h0}) begin
            n_fail++; $display("FAIL readback_strobe: rd=%b wr=%b addr=%h din=%h, required 1 0 20 0", MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DATA_IN);
        end
        tick();
        n_chk++;
        if ({ACK1, RDATA1, RDATA0} !== {1'b1, 32'h1234_5678, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL readback_data: ack1=%b rdata1=%h rdata0=%h, required 1 12345678 deadbeef", ACK1, RDATA1, RDATA0);
        end
        REQ1 = 0;
        tick();
    endtask

    task automatic test_contention();
        int exp;
        do_reset();
        REQ0 = 1; REQ1 = 1; WE0 = 0; WE1 = 0; ADDR0 = 26'h10; ADDR1 = 26'h20;
        for (int k = 0; k < 4; k++) begin
            exp = k % 2;
            tick();
            n_chk++;
            if ({MEM_READ, MEM_ADDR} !== {1'b1, (exp == 1) ? 26'h20 : 26'h10}) begin
                n_fail++; $display("FAIL contention_grant%0d: rd=%b addr=%h, required requester %0d", k, MEM_READ, MEM_ADDR, exp);
            end
            tick();
            n_chk++;
            if ({ACK0, ACK1} !== {exp == 0, exp == 1}) begin
                n_fail++; $display("FAIL contention_ack%0d: ack=%b%b, required requester %0d", k, ACK0, ACK1, exp);
            end
            tick();
            n_chk++;
            if ({MEM_READ, MEM_WRITE, ACK0, ACK1} !== 4'b0) begin
                n_fail++; $display("FAIL contention_idle%0d: rd=%b wr=%b ack=%b%b, required all 0", k, MEM_READ, MEM_WRITE, ACK0, ACK1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_latency();
        int strobes = 0, acks = 0, rise0 = -1, rise1 = -1, ack_at = -1;
        logic prev = 0;
        do_reset();
        REQ0 = 1; WE0 = 0; ADDR0 = 26'h44;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c <= 10) begin
                if (l3_rd) strobes++;
                if (l3_ack0) begin acks++; if (ack_at < 0) ack_at = c; end
            end
            if (l3_rd && !prev) begin
                if (rise0 < 0) rise0 = c; else if (rise1 < 0) rise1 = c;
            end
            prev = l3_rd;
        end
        n_chk++;
        if ({strobes, acks, rise0, rise1, ack_at} !== {32'd6, 32'd2, 32'd1, 32'd6, 32'd4}) begin
            n_fail++; $display("FAIL latency3_timing: strobes=%0d acks=%0d rise=%0d,%0d ack_at=%0d, required 6 2 1,6 4", strobes, acks, rise0, rise1, ack_at);
        end
        n_chk++;
        if (l3_rdata0 !== init_val(8'h44)) begin
            n_fail++; $display("FAIL latency3_rdata: got %h, required %h", l3_rdata0, init_val(8'h44));
        end
        idle_inputs();
    endtask

    task automatic test_input_change();
        do_reset();
        REQ0 = 1; WE0 = 0; ADDR0 = 26'h10;
        tick();
        ADDR0 = 26'h30;
        n_chk++;
        if ({MEM_ADDR, l3_maddr} !== {26'h10, 26'h10}) begin
            n_fail++; $display("FAIL input_change_c1: addr L1=%h L3=%h, required 10 10", MEM_ADDR, l3_maddr);
        end
        tick();
        n_chk++;
        if ({l3_maddr, ACK0, RDATA0} !== {26'h10, 1'b1, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL input_change_c2: L3 addr=%h L1 ack0=%b rdata0=%h, required 10 1 deadbeef", l3_maddr, ACK0, RDATA0);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        logic [127:0] obs;
        do_reset();
        REQ0 = 1; WE0 = 1; ADDR0 = 26'h50; WDATA0 = 32'hCAFE_F00D;
        tick();
        n_chk++;
        if ({MEM_WRITE, l3_wr} !== 2'b11) begin
            n_fail++; $display("FAIL midreset_pre: wr L1=%b L3=%b, required 11", MEM_WRITE, l3_wr);
        end
        RST = 0;
        #1;
        obs = {MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DATA_IN, ACK0, ACK1,
               l3_rd, l3_wr, l3_maddr, l3_mdin, l3_ack0, l3_ack1};
        n_chk++;
        if (obs !== '0) begin n_fail++; $display("FAIL midreset_async: outputs %h, required 0", obs); end
        WE0 = 0; ADDR0 = 26'h10; REQ1 = 1; WE1 = 0; ADDR1 = 26'h20;
        tick();
        RST = 1;
        tick();
        n_chk++;
        if ({MEM_READ, MEM_ADDR, l3_rd, l3_maddr, ACK0, l3_ack0} !== {1'b1, 26'h10, 1'b1, 26'h10, 2'b00}) begin
            n_fail++; $display("FAIL midreset_first_grant: L1 rd=%b addr=%h L3 rd=%b addr=%h acks=%b%b, required requester 0", MEM_READ, MEM_ADDR, l3_rd, l3_maddr, ACK0, l3_ack0);
        end
        idle_inputs();
    endtask

    // Transaction-level model: an access granted at edge t0 owns the memory
    // for MEM_LATENCY cycles, acks at t0+L, and the next grant is no earlier than t0+L+2.
    task automatic test_random();
        localparam int LAT = 1;
        logic [31:0] mm [0:255];
        logic [31:0] rd [2];
        bit pend [2];
        int free_at = 0, t0 = -100, g = 0;
        bit last = 1;
        logic m_we = 0; logic [25:0] m_addr = '0; logic [31:0] m_wd = '0;
        logic [125:0] exp_v, obs_v;
        bit strobe, ack;
        mem_init();
        for (int i = 0; i < 256; i++) mm[i] = dmem[i];
        rd[0] = '0; rd[1] = '0; pend[0] = 0; pend[1] = 0;
        do_reset();
        for (int e = 1; e <= 300; e++) begin
            if (e >= free_at && (REQ0 || REQ1)) begin
                g = (REQ0 && REQ1) ? int'(!last) : int'(REQ1);
                last = (g == 1);
                t0 = e; free_at = e + LAT + 2;
                m_we = g ? WE1 : WE0; m_addr = g ? ADDR1 : ADDR0; m_wd = g ? WDATA1 : WDATA0;
                if (m_we) mm[m_addr[7:0]] = m_wd;
            end
            strobe = (e >= t0) && (e < t0 + LAT);
            ack = (e == t0 + LAT);
            if (ack && !m_we) rd[g] = mm[m_addr[7:0]];
            exp_v = {strobe && !m_we, strobe && m_we, strobe ? m_addr : 26'h0,
                     (strobe && m_we) ? m_wd : 32'h0, ack && g == 0, ack && g == 1, rd[0], rd[1]};
            tick();
            obs_v = {MEM_READ, MEM_WRITE, MEM_ADDR, MEM_DATA_IN, ACK0, ACK1, RDATA0, RDATA1};
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h, required %h", e, obs_v, exp_v);
            end
            for (int r = 0; r < 2; r++) begin
                if (pend[r] && ack && g == r) pend[r] = 0;
                else if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1;
                    if (r == 0) begin WE0 = 1'($urandom); ADDR0 = 26'($urandom_range(0, 15)); WDATA0 = $urandom; end
                    else        begin WE1 = 1'($urandom); ADDR1 = 26'($urandom_range(0, 15)); WDATA1 = $urandom; end
                end
            end
            REQ0 = pend[0]; REQ1 = pend[1];
        end
        idle_inputs();
    endtask

    initial begin
        mem_init();
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_latency();
        test_input_change();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
